// File: rtl/pll_lock_supervisor.sv
// Supervises a Gowin rPLL from its reference clock: pulses the PLL reset, qualifies LOCK,
// and releases the downstream reset domains one by one once lock has proven stable.
module pll_lock_supervisor #(
  parameter int NUM_DOMAINS         = 3,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGGER_CYCLES      = 8,
  parameter int CNT_W               = 8
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic                   pll_lock,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [CNT_W-1:0]       relock_count,
  output logic                   timeout_err
);

  localparam int RW = $clog2(PLL_RST_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int GW = $clog2((NUM_DOMAINS - 1) * STAGGER_CYCLES + 1) + 1;

  localparam logic [RW-1:0]    RST_LAST   = RW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]    STB_LAST   = SW'(LOCK_STABLE_CYCLES - 1);
  localparam bit               STB_ONE    = (LOCK_STABLE_CYCLES == 1);
  localparam logic [CNT_W-1:0] RELOCK_MAX = '1;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN
  } state_e;

  state_e                 state_q;
  logic                   sync_q;
  logic                   lock_s_q;
  logic [RW-1:0]          rst_cnt_q;
  logic [TW-1:0]          to_cnt_q;
  logic [SW-1:0]          stb_cnt_q;
  logic [GW-1:0]          stg_cnt_q;
  logic                   pll_rst_q;
  logic [NUM_DOMAINS-1:0] domain_rst_q;
  logic                   ready_q;
  logic [CNT_W-1:0]       relock_q;
  logic                   timeout_err_q;

  logic [NUM_DOMAINS-1:0] rel_mask_d;
  logic [NUM_DOMAINS-1:0] domain_rst_d;
  logic [CNT_W-1:0]       relock_d;
  logic                   lock_lost;

  // Domain k is released on the RELEASE edge where the stagger count equals k*STAGGER_CYCLES.
  always_comb begin
    rel_mask_d = '0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if (stg_cnt_q == GW'(k * STAGGER_CYCLES)) rel_mask_d[k] = 1'b1;
    end
  end

  assign domain_rst_d = domain_rst_q & ~rel_mask_d;
  assign relock_d     = (relock_q == RELOCK_MAX) ? relock_q : relock_q + CNT_W'(1);
  assign lock_lost    = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_s_q;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync_q        <= 1'b0;
      lock_s_q      <= 1'b0;
      state_q       <= ST_PLL_RST;
      rst_cnt_q     <= '0;
      to_cnt_q      <= '0;
      stb_cnt_q     <= '0;
      stg_cnt_q     <= '0;
      pll_rst_q     <= 1'b1;
      domain_rst_q  <= '1;
      ready_q       <= 1'b0;
      relock_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      sync_q   <= pll_lock;
      lock_s_q <= sync_q;
      if (lock_lost) begin
        // Losing lock after release drops every domain at once and restarts the PLL.
        state_q      <= ST_PLL_RST;
        pll_rst_q    <= 1'b1;
        domain_rst_q <= '1;
        ready_q      <= 1'b0;
        relock_q     <= relock_d;
        rst_cnt_q    <= '0;
        to_cnt_q     <= '0;
        stb_cnt_q    <= '0;
        stg_cnt_q    <= '0;
      end else begin
        case (state_q)
          ST_PLL_RST: begin
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            if (rst_cnt_q == RST_LAST) begin
              state_q   <= ST_WAIT_LOCK;
              pll_rst_q <= 1'b0;
              rst_cnt_q <= '0;
              to_cnt_q  <= '0;
            end else begin
              rst_cnt_q <= rst_cnt_q + RW'(1);
            end
          end
          ST_WAIT_LOCK: begin
            if (lock_s_q) begin
              state_q   <= ST_STABLE;
              stb_cnt_q <= SW'(1);
              to_cnt_q  <= '0;
            end else if (to_cnt_q == TO_LAST) begin
              state_q       <= ST_PLL_RST;
              pll_rst_q     <= 1'b1;
              timeout_err_q <= 1'b1;
              rst_cnt_q     <= '0;
              to_cnt_q      <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end
          ST_STABLE: begin
            // A dropout here is treated as a glitch: requalify from scratch, no relock event.
            if (!lock_s_q) begin
              state_q   <= ST_WAIT_LOCK;
              to_cnt_q  <= '0;
              stb_cnt_q <= '0;
            end else if (STB_ONE || (stb_cnt_q == STB_LAST)) begin
              state_q   <= ST_RELEASE;
              stb_cnt_q <= '0;
              stg_cnt_q <= '0;
            end else begin
              stb_cnt_q <= stb_cnt_q + SW'(1);
            end
          end
          ST_RELEASE: begin
            domain_rst_q <= domain_rst_d;
            stg_cnt_q    <= stg_cnt_q + GW'(1);
            if (rel_mask_d[NUM_DOMAINS-1]) begin
              state_q   <= ST_RUN;
              ready_q   <= 1'b1;
              stg_cnt_q <= '0;
            end
          end
          ST_RUN: begin
          end
          default: begin
            state_q      <= ST_PLL_RST;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst   = domain_rst_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises a Gowin rPLL from its always-running reference clock.
- Drives the PLL RESET pin, synchronises and debounces the asynchronous LOCK output, and releases NUM_DOMAINS downstream reset lines in a staggered sequence once lock is proven stable.
- On lock loss, times out or retries; records relock and timeout events for debug.
- Sits between the PLL wrapper and the PSRAM controller, cart bus logic and other consumers of the PLL clock.

Parameters:
NUM_DOMAINS, 3, number of downstream reset outputs (1..8)
PLL_RST_CYCLES, 16, clkin cycles pll_rst is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before retry (>LOCK_STABLE_CYCLES)
STAGGER_CYCLES, 8, cycles between successive domain reset releases (>=1)
CNT_W, 8, width of relock_count

Ports:
clkin  in  1  reference clock (27 MHz), free-running
reset  in  1  asynchronous, active-high; all state to reset values immediately
pll_lock  in  1  rPLL LOCK, asynchronous to clkin
pll_rst  out  1  to rPLL RESET, active-high
domain_rst  out  NUM_DOMAINS  per-domain reset, active-high; bit k released k-th
ready  out  1  high only in RUN (all domains released, lock stable)
relock_count  out  CNT_W  lock-loss events seen in RELEASE/RUN, saturating
timeout_err  out  1  sticky; set on any WAIT_LOCK timeout, cleared only by reset

Behaviour:
- Reset values: state=PLL_RST, counters=0, pll_rst=1, domain_rst=all 1, ready=0, relock_count=0, timeout_err=0, sync flops=0.
- pll_lock passes through a 2-flop synchroniser; lock_s is the second flop. Synchronisation latency is 2 edges. All decisions use lock_s only.
- PLL_RST: pll_rst=1, domain_rst=all 1. The counter runs for PLL_RST_CYCLES edges, then the state moves to WAIT_LOCK, pll_rst=0 and the counter clears.
- WAIT_LOCK: the timeout counter increments each cycle.
  - lock_s=1: go to STABLE, stable counter=1.
  - Timeout counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0: set timeout_err and go to PLL_RST (retry, unlimited).
- STABLE: the stable counter increments while lock_s=1.
  - Any lock_s=0: return to WAIT_LOCK with the timeout counter cleared. This is a glitch; no relock_count increment.
  - Stable counter reaches LOCK_STABLE_CYCLES: go to RELEASE with the stagger counter cleared.
- RELEASE: the stagger counter increments each cycle.
  - domain_rst[k] clears on the edge where the counter equals k*STAGGER_CYCLES, so domain 0 clears on the first RELEASE edge.
  - Released bits stay low.
  - When domain NUM_DOMAINS-1 clears, the state moves to RUN and ready=1 on the same edge.
- RUN: hold all outputs. lock_s=0 triggers lock-loss handling.
- Lock loss (lock_s=0 in RELEASE or RUN): on the next edge, and in a single cycle:
  - domain_rst=all 1, ready=0, pll_rst=1;
  - state=PLL_RST with counters cleared;
  - relock_count increments, saturating at 2^CNT_W-1.
- Domain resets are asserted only via lock loss or reset. Once released they never toggle individually.
- Reset asserted mid-sequence: immediate return to reset values; relock_count and timeout_err are lost.
- NUM_DOMAINS=1: RELEASE lasts one edge, and domain 0 and ready change together.
- Counter widths are derived with $clog2 of each limit plus 1. No wrap can occur before the terminal compare.

Test Plan:
(Params: NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, STAGGER_CYCLES=2, CNT_W=4.)
- Cold start: deassert reset, pll_lock=1 throughout -> pll_rst high for 4 edges; lock_s high 2 edges later; after 8 stable edges domain_rst goes 111 -> 110 -> 100 -> 000 on edges R, R+2, R+4; ready=1 at R+4; relock_count=0.
- Lock glitch in STABLE: pll_lock low for 3 cycles after 5 stable cycles -> return to WAIT_LOCK, domain_rst stays 111, relock_count stays 0; release occurs 8 stable cycles after lock returns.
- Lock loss in RUN: drop pll_lock -> 3 edges later (2 sync + 1) domain_rst=111, ready=0, pll_rst=1 for 4 edges, relock_count=1; relock repeats the full sequence. 17 losses -> relock_count saturates at 15.
- Timeout: pll_lock held 0 -> timeout_err=1 after 32 WAIT_LOCK cycles, pll_rst re-pulses 4 cycles, and this repeats; a later lock completes the sequence with timeout_err still 1.
- Loss mid-RELEASE: drop lock after domain 0 releases -> all domain_rst back to 111 together, ready never asserts, relock_count=1.
- Async reset in RUN: assert reset between edges -> outputs return to reset values without waiting for a clock edge; counters cleared.
